// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// ID-stage hazard controller. It decodes the instruction held in IF/ID and
// keeps a small per-register scoreboard of outstanding load destinations.
// When a source register is still waiting on a load, it inserts a bubble.
// After a control-flow op issues, a shadow FSM bubbles for BR_SHADOW flow
// cycles. It then resolves the op and squashes the wrong-path instruction
// in ID if the op was unconditional or the branch was taken.
//
// Parameters:
//   LOAD_LAT   bubbles between a load and a dependent consumer (1..3)
//   BR_SHADOW  bubble cycles after a control-flow op issues (0..7)
//   NREG       architectural registers tracked (8)
//
// Ports:
//   clk         pipeline clock, rising edge
//   rst_n       asynchronous active-low reset
//   flow        ID/EX advance enable; all state is frozen when low
//   id_valid    IF/ID holds a real instruction
//   id_ir       IF/ID instruction register
//   br_taken    branch enable from the resolving stage (used in RESOLVE)
//   gen_bubble  insert NOP into ID/EX and hold IF/ID
//   squash_id   replace IF/ID contents with NOP
//   stall_cnt   count of flow cycles with gen_bubble=1
//   squash_cnt  count of flow cycles with squash_id=1
//
// Build option:
//   HAZARD_PERF_EN  when defined, builds the two 32-bit performance
//                   counters. Otherwise stall_cnt and squash_cnt read 0.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int LOAD_LAT  = 1,
  parameter int BR_SHADOW = 4,
  parameter int NREG      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flow,
  input  logic        id_valid,
  input  logic [15:0] id_ir,
  input  logic        br_taken,
  output logic        gen_bubble,
  output logic        squash_id,
  output logic [31:0] stall_cnt,
  output logic [31:0] squash_cnt
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHADOW,
    RESOLVE
  } state_t;

  state_t      state_q;
  logic [2:0]  shadow_cnt_q;
  logic        uncond_q;

  logic [CW-1:0] sb_q [NREG];
  logic [CW-1:0] sb_d [NREG];

  // Instruction decode
  logic [3:0] opc;
  logic [2:0] sr1, sr2, sd, dr;
  logic op_add, op_and, op_xor, op_shf;
  logic op_ldb, op_ldw, op_ldi;
  logic op_stb, op_stw, op_sti;
  logic op_br, op_jmp, op_jsr, op_jsrr, op_trap;
  logic use_sr1, use_sr2, use_sd;
  logic is_load, is_cf;
  logic hazard;
  logic issue;

  assign opc = id_ir[15:12];
  assign sr1 = id_ir[8:6];
  assign sr2 = id_ir[2:0];
  assign sd  = id_ir[11:9];
  assign dr  = id_ir[11:9];

  assign op_br   = (opc == 4'b0000) && (id_ir != 16'h0000);
  assign op_add  = (opc == 4'b0001);
  assign op_ldb  = (opc == 4'b0010);
  assign op_stb  = (opc == 4'b0011);
  assign op_jsr  = (opc == 4'b0100);
  assign op_and  = (opc == 4'b0101);
  assign op_ldw  = (opc == 4'b0110);
  assign op_stw  = (opc == 4'b0111);
  assign op_xor  = (opc == 4'b1001);
  assign op_ldi  = (opc == 4'b1010);
  assign op_sti  = (opc == 4'b1011);
  assign op_jmp  = (opc == 4'b1100);
  assign op_shf  = (opc == 4'b1101);
  assign op_trap = (opc == 4'b1111);

  // JSRR is the register-based form of JSR. It is the only form that
  // reads SR1.
  assign op_jsrr = op_jsr & ~id_ir[11];

  assign use_sr1 = op_add | op_and | op_xor | op_shf | op_ldb | op_ldw |
                   op_ldi | op_stb | op_stw | op_sti | op_jmp | op_jsrr;
  assign use_sr2 = (op_add | op_and | op_xor) & ~id_ir[5];
  assign use_sd  = op_stb | op_stw | op_sti;

  assign is_load = op_ldb | op_ldw | op_ldi;
  assign is_cf   = op_br | op_jmp | op_jsr | op_trap;

  assign hazard = (use_sr1 && (sb_q[sr1] != '0)) ||
                  (use_sr2 && (sb_q[sr2] != '0)) ||
                  (use_sd  && (sb_q[sd]  != '0));

  // Outputs depend only on the current state and the instruction in ID.
  // There is no extra cycle of latency.
  always_comb begin
    gen_bubble = 1'b0;
    squash_id  = 1'b0;
    case (state_q)
      IDLE:    gen_bubble = hazard & id_valid;
      SHADOW:  gen_bubble = 1'b1;
      RESOLVE: squash_id  = id_valid & (uncond_q | br_taken);
      default: begin
        gen_bubble = 1'b0;
        squash_id  = 1'b0;
      end
    endcase
  end

  assign issue = flow & id_valid & ~gen_bubble & ~squash_id;

  // Scoreboard next state. Every pending count ages by one per flow cycle.
  // A newly issued load overwrites its destination entry, so a back-to-back
  // reload of the same register restarts its full latency.
  always_comb begin
    sb_d = sb_q;
    if (flow) begin
      for (int i = 0; i < NREG; i++) begin
        if (sb_q[i] != '0) begin
          sb_d[i] = sb_q[i] - CW'(1);
        end
      end
      if (issue && is_load) begin
        sb_d[dr] = CW'(LOAD_LAT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  // Control-flow shadow FSM. The shadow counter is loaded with BR_SHADOW.
  // The FSM leaves SHADOW on the flow cycle in which the counter reaches 1,
  // which yields exactly BR_SHADOW bubble cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_cnt_q <= 3'd0;
      uncond_q     <= 1'b0;
    end else if (flow) begin
      case (state_q)
        IDLE: begin
          if (issue && is_cf) begin
            uncond_q <= ~op_br;
            if (BR_SHADOW == 0) begin
              state_q <= RESOLVE;
            end else begin
              state_q      <= SHADOW;
              shadow_cnt_q <= 3'(BR_SHADOW);
            end
          end
        end
        SHADOW: begin
          if (shadow_cnt_q == 3'd1) begin
            state_q <= RESOLVE;
          end
          shadow_cnt_q <= shadow_cnt_q - 3'd1;
        end
        RESOLVE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] squash_cnt_q;

  // Performance counters. Both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else if (flow) begin
      if (gen_bubble) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (squash_id) begin
        squash_cnt_q <= squash_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  assign stall_cnt  = 32'h0;
  assign squash_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Testbench for hazard_ctrl. It uses two instances:
//   dutA  LOAD_LAT=1, BR_SHADOW=4 (default configuration)
//   dutB  LOAD_LAT=2, BR_SHADOW=0 (longer load latency, direct resolve)
//
// Each scenario is a table of per-cycle steps. A step holds the inputs and
// the {gen_bubble, squash_id} values expected for that cycle. Driving a step
// pushes its expectation onto a queue. The scenario then pops the queue and
// compares it against the DUT outputs after the inputs have settled.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

`ifdef HAZARD_PERF_EN
  localparam logic [31:0] PERF_STALL  = 32'd4;
  localparam logic [31:0] PERF_SQUASH = 32'd1;
`else
  localparam logic [31:0] PERF_STALL  = 32'd0;
  localparam logic [31:0] PERF_SQUASH = 32'd0;
`endif

  typedef struct packed {
    logic        rn;
    logic        f;
    logic        v;
    logic        bt;
    logic        gb;
    logic        sq;
    logic [15:0] ir;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        flow, id_valid, br_taken;
  logic [15:0] id_ir;
  logic        gen_bubble, squash_id;
  logic [31:0] stall_cnt, squash_cnt;

  logic        flowB, idValidB, brTakenB;
  logic [15:0] idIrB;
  logic        genBubbleB, squashIdB;
  logic [31:0] stallCntB, squashCntB;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] expQ[$];
  logic [1:0] expQB[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .BR_SHADOW(4), .NREG(8)) dutA (
    .clk        (clk),
    .rst_n      (rst_n),
    .flow       (flow),
    .id_valid   (id_valid),
    .id_ir      (id_ir),
    .br_taken   (br_taken),
    .gen_bubble (gen_bubble),
    .squash_id  (squash_id),
    .stall_cnt  (stall_cnt),
    .squash_cnt (squash_cnt)
  );

  hazard_ctrl #(.LOAD_LAT(2), .BR_SHADOW(0), .NREG(8)) dutB (
    .clk        (clk),
    .rst_n      (rst_n),
    .flow       (flowB),
    .id_valid   (idValidB),
    .id_ir      (idIrB),
    .br_taken   (brTakenB),
    .gen_bubble (genBubbleB),
    .squash_id  (squashIdB),
    .stall_cnt  (stallCntB),
    .squash_cnt (squashCntB)
  );

  function automatic step_t st(input logic rn, input logic f, input logic v,
                               input logic bt, input logic gb, input logic sq,
                               input logic [15:0] ir);
    step_t s;
    s.rn = rn;
    s.f  = f;
    s.v  = v;
    s.bt = bt;
    s.gb = gb;
    s.sq = sq;
    s.ir = ir;
    return s;
  endfunction

  task automatic driveA(input step_t s);
    rst_n    = s.rn;
    flow     = s.f;
    id_valid = s.v;
    br_taken = s.bt;
    id_ir    = s.ir;
    expQ.push_back({s.gb, s.sq});
  endtask

  task automatic driveB(input step_t s);
    rst_n    = s.rn;
    flowB    = s.f;
    idValidB = s.v;
    brTakenB = s.bt;
    idIrB    = s.ir;
    expQB.push_back({s.gb, s.sq});
  endtask

  // Reset state of both instances, including the performance counters.
  task automatic test_reset();
    rst_n    = 1'b0;
    flow     = 1'b1;
    id_valid = 1'b1;
    br_taken = 1'b1;
    id_ir    = 16'h1443;
    flowB    = 1'b1;
    idValidB = 1'b1;
    brTakenB = 1'b1;
    idIrB    = 16'h1443;
    @(negedge clk);
    compared++;
    if ({gen_bubble, squash_id} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_outA: got %b required 00", {gen_bubble, squash_id});
    end
    compared++;
    if ({genBubbleB, squashIdB} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_outB: got %b required 00", {genBubbleB, squashIdB});
    end
    compared++;
    if (stall_cnt !== 32'd0 || squash_cnt !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_perfA: stall=%0d squash=%0d required 0/0", stall_cnt, squash_cnt);
    end
    compared++;
    if (stallCntB !== 32'd0 || squashCntB !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_perfB: stall=%0d squash=%0d required 0/0", stallCntB, squashCntB);
    end
    rst_n    = 1'b1;
    flow     = 1'b0;
    id_valid = 1'b0;
    br_taken = 1'b0;
    flowB    = 1'b0;
    idValidB = 1'b0;
    brTakenB = 1'b0;
    @(negedge clk);
  endtask

  // LOAD_LAT=1 load-use bubbles, independent consumer, flow freeze,
  // id_valid gating.
  task automatic test_load_use();
    step_t tbl[$];
    logic [1:0] expVal;
    tbl.push_back(st(H,H,H,L,L,L,16'h6200));
    tbl.push_back(st(H,H,H,L,H,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h6200));
    tbl.push_back(st(H,H,H,L,L,L,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h6200));
    tbl.push_back(st(H,L,H,L,H,L,16'h1443));
    tbl.push_back(st(H,L,H,L,H,L,16'h1443));
    tbl.push_back(st(H,H,H,L,H,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h6200));
    tbl.push_back(st(H,H,L,L,L,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h1443));
    foreach (tbl[i]) begin
      driveA(tbl[i]);
      #1;
      expVal = expQ.pop_front();
      compared++;
      if ({gen_bubble, squash_id} !== expVal) begin
        mismatched++;
        $display("[TB] FAIL load_use step %0d: {gen_bubble,squash_id}=%b required %b",
                 i, {gen_bubble, squash_id}, expVal);
      end
      @(negedge clk);
    end
  endtask

  // Conditional branch with BR_SHADOW=4, taken then not taken.
  task automatic test_branch();
    step_t tbl[$];
    logic [1:0] expVal;
    tbl.push_back(st(H,H,H,L,L,L,16'h0E05));
    for (int k = 0; k < 4; k++) tbl.push_back(st(H,H,H,L,H,L,16'h1880));
    tbl.push_back(st(H,H,H,H,L,H,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h0E05));
    for (int k = 0; k < 4; k++) tbl.push_back(st(H,H,H,H,H,L,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h1880));
    tbl.push_back(st(H,H,H,H,L,L,16'h1880));
    foreach (tbl[i]) begin
      driveA(tbl[i]);
      #1;
      expVal = expQ.pop_front();
      compared++;
      if ({gen_bubble, squash_id} !== expVal) begin
        mismatched++;
        $display("[TB] FAIL branch step %0d: {gen_bubble,squash_id}=%b required %b",
                 i, {gen_bubble, squash_id}, expVal);
      end
      @(negedge clk);
    end
  endtask

  // JMP after a fresh reset. A zero instruction does not enter the shadow.
  // The performance counters are checked at the end.
  task automatic test_jmp_perf();
    step_t tbl[$];
    logic [1:0] expVal;
    tbl.push_back(st(L,H,H,H,L,L,16'hC1C0));
    tbl.push_back(st(H,H,H,L,L,L,16'hC1C0));
    for (int k = 0; k < 4; k++) tbl.push_back(st(H,H,H,L,H,L,16'h1880));
    tbl.push_back(st(H,H,H,L,L,H,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h0000));
    tbl.push_back(st(H,H,H,L,L,L,16'h1880));
    foreach (tbl[i]) begin
      driveA(tbl[i]);
      #1;
      expVal = expQ.pop_front();
      compared++;
      if ({gen_bubble, squash_id} !== expVal) begin
        mismatched++;
        $display("[TB] FAIL jmp step %0d: {gen_bubble,squash_id}=%b required %b",
                 i, {gen_bubble, squash_id}, expVal);
      end
      @(negedge clk);
    end
    compared++;
    if (stall_cnt !== PERF_STALL) begin
      mismatched++;
      $display("[TB] FAIL perf_stall: stall_cnt=%0d required %0d", stall_cnt, PERF_STALL);
    end
    compared++;
    if (squash_cnt !== PERF_SQUASH) begin
      mismatched++;
      $display("[TB] FAIL perf_squash: squash_cnt=%0d required %0d", squash_cnt, PERF_SQUASH);
    end
  endtask

  // flow=0 for three cycles in the shadow still gives exactly 4 flow-cycle
  // bubbles. A frozen RESOLVE keeps squashing until flow returns.
  task automatic test_flow_freeze();
    step_t tbl[$];
    logic [1:0] expVal;
    tbl.push_back(st(H,H,H,L,L,L,16'h0E05));
    tbl.push_back(st(H,H,H,L,H,L,16'h1880));
    for (int k = 0; k < 3; k++) tbl.push_back(st(H,L,H,L,H,L,16'h1880));
    for (int k = 0; k < 3; k++) tbl.push_back(st(H,H,H,L,H,L,16'h1880));
    tbl.push_back(st(H,L,H,H,L,H,16'h1880));
    tbl.push_back(st(H,H,L,H,L,L,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h1880));
    foreach (tbl[i]) begin
      driveA(tbl[i]);
      #1;
      expVal = expQ.pop_front();
      compared++;
      if ({gen_bubble, squash_id} !== expVal) begin
        mismatched++;
        $display("[TB] FAIL flow_freeze step %0d: {gen_bubble,squash_id}=%b required %b",
                 i, {gen_bubble, squash_id}, expVal);
      end
      @(negedge clk);
    end
  endtask

  // Reset asserted at bubble 2 of a shadow, then while squashing in RESOLVE.
  // No squash may follow either release.
  task automatic test_reset_mid();
    step_t tbl[$];
    logic [1:0] expVal;
    tbl.push_back(st(H,H,H,L,L,L,16'h0E05));
    tbl.push_back(st(H,H,H,L,H,L,16'h1880));
    tbl.push_back(st(L,H,H,H,L,L,16'h1880));
    tbl.push_back(st(H,H,H,H,L,L,16'h1880));
    tbl.push_back(st(H,H,H,H,L,L,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'hC1C0));
    for (int k = 0; k < 4; k++) tbl.push_back(st(H,H,H,L,H,L,16'h1880));
    tbl.push_back(st(H,L,H,L,L,H,16'h1880));
    tbl.push_back(st(L,H,H,L,L,L,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h1880));
    tbl.push_back(st(H,H,H,H,L,L,16'h1880));
    foreach (tbl[i]) begin
      driveA(tbl[i]);
      #1;
      expVal = expQ.pop_front();
      compared++;
      if ({gen_bubble, squash_id} !== expVal) begin
        mismatched++;
        $display("[TB] FAIL reset_mid step %0d: {gen_bubble,squash_id}=%b required %b",
                 i, {gen_bubble, squash_id}, expVal);
      end
      @(negedge clk);
    end
  endtask

  // LOAD_LAT=2: store and ADD consumers, set-over-decrement, immediate ADD
  // (no SR2), and LDI/STI.
  task automatic test_load_lat2();
    step_t tbl[$];
    logic [1:0] expVal;
    tbl.push_back(st(H,H,H,L,L,L,16'h6200));
    tbl.push_back(st(H,H,H,L,H,L,16'h3240));
    tbl.push_back(st(H,H,H,L,H,L,16'h3240));
    tbl.push_back(st(H,H,H,L,L,L,16'h3240));
    tbl.push_back(st(H,H,H,L,L,L,16'h6200));
    tbl.push_back(st(H,H,H,L,L,L,16'h1880));
    tbl.push_back(st(H,H,H,L,H,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h6200));
    tbl.push_back(st(H,H,H,L,L,L,16'h6200));
    tbl.push_back(st(H,H,H,L,H,L,16'h1443));
    tbl.push_back(st(H,H,H,L,H,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h6600));
    tbl.push_back(st(H,H,H,L,L,L,16'h1463));
    tbl.push_back(st(H,H,H,L,H,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'h1443));
    tbl.push_back(st(H,H,H,L,L,L,16'hA200));
    tbl.push_back(st(H,H,H,L,H,L,16'hB040));
    tbl.push_back(st(H,H,H,L,H,L,16'hB040));
    tbl.push_back(st(H,H,H,L,L,L,16'hB040));
    foreach (tbl[i]) begin
      driveB(tbl[i]);
      #1;
      expVal = expQB.pop_front();
      compared++;
      if ({genBubbleB, squashIdB} !== expVal) begin
        mismatched++;
        $display("[TB] FAIL load_lat2 step %0d: {gen_bubble,squash_id}=%b required %b",
                 i, {genBubbleB, squashIdB}, expVal);
      end
      @(negedge clk);
    end
  endtask

  // BR_SHADOW=0 goes straight to RESOLVE. A load-use hazard blocks the JMP.
  // Covers BR, JSR and TRAP resolution.
  task automatic test_shadow_zero();
    step_t tbl[$];
    logic [1:0] expVal;
    tbl.push_back(st(H,H,H,L,L,L,16'h6E00));
    tbl.push_back(st(H,H,H,L,H,L,16'hC1C0));
    tbl.push_back(st(H,H,H,L,H,L,16'hC1C0));
    tbl.push_back(st(H,H,H,L,L,L,16'hC1C0));
    tbl.push_back(st(H,H,H,L,L,H,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h0E05));
    tbl.push_back(st(H,H,H,L,L,L,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h0E05));
    tbl.push_back(st(H,H,H,H,L,H,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'h4800));
    tbl.push_back(st(H,H,L,L,L,L,16'h1880));
    tbl.push_back(st(H,H,H,L,L,L,16'hF025));
    tbl.push_back(st(H,H,H,L,L,H,16'h1880));
    tbl.push_back(st(H,H,H,H,L,L,16'h1880));
    foreach (tbl[i]) begin
      driveB(tbl[i]);
      #1;
      expVal = expQB.pop_front();
      compared++;
      if ({genBubbleB, squashIdB} !== expVal) begin
        mismatched++;
        $display("[TB] FAIL shadow_zero step %0d: {gen_bubble,squash_id}=%b required %b",
                 i, {genBubbleB, squashIdB}, expVal);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_jmp_perf();
    test_flow_freeze();
    test_reset_mid();
    flow     = 1'b0;
    id_valid = 1'b0;
    test_load_lat2();
    test_shadow_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
